// File: rtl/ray_gen_sequencer.sv
// ray_gen_sequencer: programmable fixed-point micro-sequencer with a 3-stage F/X/W
// pipeline. It runs a host-loaded program for N iterations and streams PUSHed words
// out over valid/ready.
`timescale 1ns/1ps
module ray_gen_sequencer #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned FRAC       = 16,
  parameter int unsigned RF_DEPTH   = 32,
  parameter int unsigned IMEM_DEPTH = 64,
  parameter int unsigned ITER_W     = 16,
  localparam int unsigned RF_AW     = $clog2(RF_DEPTH),
  localparam int unsigned IMEM_AW   = $clog2(IMEM_DEPTH),
  localparam int unsigned INSN_W    = 3 + 3 * RF_AW,
  localparam int unsigned HADDR_W   = ((IMEM_AW > RF_AW) ? IMEM_AW : RF_AW) + 1
) (
  input  logic               iClock,
  input  logic               iReset_n,
  input  logic               iStart,
  input  logic [ITER_W-1:0]  iIterations,
  output logic               oBusy,
  output logic               oDone,
  output logic               oOutValid,
  output logic [DATA_W-1:0]  oOutData,
  input  logic               iOutReady,
  input  logic               iHostSelected,
  input  logic               iHostWrite,
  input  logic [HADDR_W-1:0] iHostAddr,
  input  logic [DATA_W-1:0]  iHostData,
  output logic [DATA_W-1:0]  oHostData
);

  localparam int unsigned SQ_STEPS = DATA_W / 2;
  localparam int unsigned SQ_CW    = $clog2(SQ_STEPS);
  localparam int unsigned REM_W    = SQ_STEPS + 3;
  localparam logic [SQ_CW-1:0] SQ_LAST = SQ_CW'(SQ_STEPS - 1);

  localparam logic [2:0] OpNop  = 3'd0;
  localparam logic [2:0] OpMul  = 3'd1;
  localparam logic [2:0] OpSub  = 3'd2;
  localparam logic [2:0] OpAdd  = 3'd3;
  localparam logic [2:0] OpShr  = 3'd4;
  localparam logic [2:0] OpSqrt = 3'd5;
  localparam logic [2:0] OpPush = 3'd6;
  localparam logic [2:0] OpHalt = 3'd7;

  typedef enum logic [1:0] {StIdle, StRun, StDrain} seqState_e;

  seqState_e           state, stateNext;
  logic                busy, done, doneNext;
  logic [ITER_W-1:0]   iterCount, iterIdx;
  logic                lastIter;
  logic [IMEM_AW-1:0]  ip;
  logic                fetchStop;

  logic                fValid;
  logic [INSN_W-1:0]   fInsn;
  logic [IMEM_AW-1:0]  fPc;

  logic                wValid, wHaltLast;
  logic [RF_AW-1:0]    wDst;
  logic [DATA_W-1:0]   wData;

  logic                outValid;
  logic [DATA_W-1:0]   outData;

  logic [DATA_W-1:0]   rf   [RF_DEPTH];
  logic [INSN_W-1:0]   imem [IMEM_DEPTH];

  logic [2:0]          xOp;
  logic [RF_AW-1:0]    xDst, xSrcA, xSrcB;
  logic [DATA_W-1:0]   opA, opB, xRes;
  logic                xWe, xStall, xHalt, pushFire;
  logic signed [2*DATA_W-1:0] mulA, mulB, prod;

  logic [SQ_CW-1:0]    sqCnt;
  logic [REM_W-1:0]    sqRem, sqRemIn, sqRemNext, remT, trial;
  logic [SQ_STEPS-1:0] sqRoot, sqRootIn, sqRootNext;
  logic [DATA_W-1:0]   sqOp, sqOpIn, sqOpNext;

  logic                hostWr, hostIsImem;

  assign hostWr     = iHostSelected & iHostWrite & ~busy;
  assign hostIsImem = iHostAddr[HADDR_W-1];
  assign lastIter   = (iterIdx == iterCount - ITER_W'(1));

  assign oBusy     = busy;
  assign oDone     = done;
  assign oOutValid = outValid;
  assign oOutData  = outData;

  // Instruction field decode; the last IMEM slot always behaves as HALT
  always_comb begin
    xOp   = fInsn[INSN_W-1 -: 3];
    xDst  = fInsn[3*RF_AW-1 -: RF_AW];
    xSrcA = fInsn[2*RF_AW-1 -: RF_AW];
    xSrcB = fInsn[RF_AW-1:0];
    if (fPc == IMEM_AW'(IMEM_DEPTH - 1)) xOp = OpHalt;
  end

  // Operand read: r0 is the iteration index, otherwise forward from W before RF
  always_comb begin
    opA = rf[xSrcA];
    opB = rf[xSrcB];
    if (xSrcA == '0) opA = DATA_W'(iterIdx);
    else if (wValid && (wDst == xSrcA)) opA = wData;
    if (xSrcB == '0) opB = DATA_W'(iterIdx);
    else if (wValid && (wDst == xSrcB)) opB = wData;
  end

  // One radix-2 square-root step; the first step seeds from operand A
  always_comb begin
    sqRemIn  = (sqCnt == '0) ? '0 : sqRem;
    sqRootIn = (sqCnt == '0) ? '0 : sqRoot;
    sqOpIn   = (sqCnt == '0) ? opA : sqOp;
    remT     = (sqRemIn << 2) | REM_W'(sqOpIn[DATA_W-1 -: 2]);
    trial    = REM_W'({sqRootIn, 2'b01});
    sqOpNext = sqOpIn << 2;
    if (remT >= trial) begin
      sqRemNext  = remT - trial;
      sqRootNext = (sqRootIn << 1) | SQ_STEPS'(1);
    end else begin
      sqRemNext  = remT;
      sqRootNext = sqRootIn << 1;
    end
  end

  // Signed fixed-point multiply operands
  always_comb begin
    mulA = (2*DATA_W)'($signed(opA));
    mulB = (2*DATA_W)'($signed(opB));
    prod = mulA * mulB;
  end

  // Execute stage: result, write enable, stall and halt detection
  always_comb begin
    xRes     = '0;
    xWe      = 1'b0;
    xStall   = 1'b0;
    xHalt    = 1'b0;
    pushFire = 1'b0;
    if (fValid) begin
      unique case (xOp)
        OpNop: ;
        OpMul: begin xRes = DATA_W'(prod >>> FRAC); xWe = 1'b1; end
        OpSub: begin xRes = opA - opB; xWe = 1'b1; end
        OpAdd: begin xRes = opA + opB; xWe = 1'b1; end
        OpShr: begin xRes = DATA_W'($signed(opA) >>> 1); xWe = 1'b1; end
        OpSqrt: begin
          if (sqCnt == SQ_LAST) begin
            xRes = DATA_W'(sqRootNext);
            xWe  = 1'b1;
          end else begin
            xStall = 1'b1;
          end
        end
        OpPush: begin
          if (!outValid || iOutReady) begin
            pushFire = 1'b1;
            xRes     = opA;
            xWe      = 1'b1;
          end else begin
            xStall = 1'b1;
          end
        end
        OpHalt: xHalt = 1'b1;
        default: ;
      endcase
    end
  end

  // Square-root iteration state
  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      sqCnt  <= '0;
      sqRem  <= '0;
      sqRoot <= '0;
      sqOp   <= '0;
    end else if (fValid && (xOp == OpSqrt)) begin
      if (sqCnt == SQ_LAST) begin
        sqCnt <= '0;
      end else begin
        sqCnt  <= sqCnt + SQ_CW'(1);
        sqRem  <= sqRemNext;
        sqRoot <= sqRootNext;
        sqOp   <= sqOpNext;
      end
    end
  end

  // Fetch stage, instruction pointer and iteration bookkeeping
  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      fValid    <= 1'b0;
      fInsn     <= '0;
      fPc       <= '0;
      ip        <= '0;
      iterIdx   <= '0;
      iterCount <= '0;
      fetchStop <= 1'b0;
    end else if (state == StIdle) begin
      fValid <= 1'b0;
      if (iStart && (iIterations != '0)) begin
        ip        <= '0;
        iterIdx   <= '0;
        iterCount <= iIterations;
        fetchStop <= 1'b0;
      end
    end else if (xHalt) begin
      fValid <= 1'b0;
      if (lastIter) begin
        fetchStop <= 1'b1;
      end else begin
        iterIdx <= iterIdx + ITER_W'(1);
        ip      <= '0;
      end
    end else if (xStall) begin
      fValid <= fValid;
    end else if ((state == StRun) && !fetchStop) begin
      fInsn  <= imem[ip];
      fPc    <= ip;
      fValid <= 1'b1;
      ip     <= ip + IMEM_AW'(1);
    end else begin
      fValid <= 1'b0;
    end
  end

  // Write-back stage register; a stall in X inserts a bubble
  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      wValid    <= 1'b0;
      wHaltLast <= 1'b0;
      wDst      <= '0;
      wData     <= '0;
    end else begin
      wValid    <= xWe && (xDst != '0);
      wHaltLast <= xHalt && lastIter;
      wDst      <= xDst;
      wData     <= xRes;
    end
  end

  // Register file: pipeline write-back, else host write while idle
  always_ff @(posedge iClock) begin
    if (wValid) rf[wDst] <= wData;
    else if (hostWr && !hostIsImem) rf[iHostAddr[RF_AW-1:0]] <= iHostData;
  end

  // Instruction memory: host writes only while idle
  always_ff @(posedge iClock) begin
    if (hostWr && hostIsImem) imem[iHostAddr[IMEM_AW-1:0]] <= iHostData[INSN_W-1:0];
  end

  // Registered host read port, available at any time
  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) oHostData <= '0;
    else if (hostIsImem) oHostData <= DATA_W'(imem[iHostAddr[IMEM_AW-1:0]]);
    else oHostData <= rf[iHostAddr[RF_AW-1:0]];
  end

  // Output register: loaded by PUSH, cleared when the consumer accepts it
  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      outValid <= 1'b0;
      outData  <= '0;
    end else if (pushFire) begin
      outValid <= 1'b1;
      outData  <= opA;
    end else if (outValid && iOutReady) begin
      outValid <= 1'b0;
    end
  end

  // Control FSM state register with registered busy/done
  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      state <= StIdle;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= stateNext;
      busy  <= (stateNext != StIdle);
      done  <= doneNext;
    end
  end

  // Control FSM next state: run, drain the output register, then signal done
  always_comb begin
    stateNext = state;
    doneNext  = 1'b0;
    unique case (state)
      StIdle: begin
        if (iStart) begin
          if (iIterations == '0) doneNext = 1'b1;
          else stateNext = StRun;
        end
      end
      StRun: begin
        if (wHaltLast) stateNext = StDrain;
      end
      StDrain: begin
        if (!outValid) begin
          stateNext = StIdle;
          doneNext  = 1'b1;
        end
      end
      default: stateNext = StIdle;
    endcase
  end

endmodule

// File: tb/tb_ray_gen_sequencer.sv
// Bench for ray_gen_sequencer: ISA-level reference model plus per-cycle output checker.
`timescale 1ns/1ps
module tb_ray_gen_sequencer;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned ITER_W     = 16;
  localparam int unsigned HADDR_W    = 7;
  localparam int          IMEM_DEPTH = 64;

  localparam logic [2:0] NOP = 3'd0, MUL = 3'd1, SUB = 3'd2, ADD = 3'd3;
  localparam logic [2:0] SHR = 3'd4, SQRT = 3'd5, PUSH = 3'd6, HALT = 3'd7;

  logic               clk;
  logic               rstN;
  logic               start;
  logic [ITER_W-1:0]  iters;
  logic               busy, done, outValid, outReady;
  logic [DATA_W-1:0]  outData;
  logic               hostSel, hostWr;
  logic [HADDR_W-1:0] hostAddr;
  logic [DATA_W-1:0]  hostWData, hostRData;

  ray_gen_sequencer dut (
    .iClock(clk), .iReset_n(rstN), .iStart(start), .iIterations(iters),
    .oBusy(busy), .oDone(done), .oOutValid(outValid), .oOutData(outData),
    .iOutReady(outReady), .iHostSelected(hostSel), .iHostWrite(hostWr),
    .iHostAddr(hostAddr), .iHostData(hostWData), .oHostData(hostRData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          nCmp = 0;
  int          nBad = 0;
  logic [31:0] expQ[$];
  logic [31:0] gotQ[$];
  int          gotT[$];
  int          cyc = 0;
  int          readyMode = 0;
  bit          checkEn = 1'b0;
  bit          prevStall = 1'b0;
  logic [31:0] rfM[32];
  logic [17:0] progM[IMEM_DEPTH];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [17:0] enc(input logic [2:0] op, input int d, input int a, input int b);
    return {op, 5'(d), 5'(a), 5'(b)};
  endfunction

  function automatic logic [31:0] mulFx(input logic [31:0] a, input logic [31:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    return 32'(p >>> 16);
  endfunction

  function automatic logic [31:0] isqrt(input logic [31:0] x);
    longint r, xl;
    xl = longint'({32'd0, x});
    r  = longint'($sqrt(real'(xl)));
    while (r * r > xl) r--;
    while ((r + 1) * (r + 1) <= xl) r++;
    return 32'(r);
  endfunction

  // Architectural execution of the loaded program for n iterations
  task automatic modelRun(input int n);
    for (int it = 0; it < n; it++) begin
      for (int pc = 0; pc < IMEM_DEPTH; pc++) begin
        logic [17:0] w;
        logic [2:0]  op;
        int          d, sa, sb;
        logic [31:0] a, b, r;
        bit          we;
        w  = progM[pc];
        op = w[17:15];
        d  = int'(w[14:10]);
        sa = int'(w[9:5]);
        sb = int'(w[4:0]);
        if (op == HALT || pc == IMEM_DEPTH - 1) break;
        a  = (sa == 0) ? 32'(it) : rfM[sa];
        b  = (sb == 0) ? 32'(it) : rfM[sb];
        r  = 32'd0;
        we = 1'b1;
        case (op)
          MUL:  r = mulFx(a, b);
          SUB:  r = a - b;
          ADD:  r = a + b;
          SHR:  r = 32'($signed(a) >>> 1);
          SQRT: r = isqrt(a);
          PUSH: begin r = a; expQ.push_back(a); end
          default: we = 1'b0;
        endcase
        if (we && d != 0) rfM[d] = r;
      end
    end
  endtask

  // Output checker and consumer: drives ready, checks every valid cycle against the model
  initial begin
    outReady = 1'b1;
    forever begin
      @(negedge clk);
      cyc++;
      if (readyMode == 0) outReady = 1'b1;
      else if (readyMode == 1) outReady = 1'($urandom_range(0, 1));
      else outReady = 1'b0;
      if (checkEn && rstN) begin
        if (prevStall) chk("out held valid", outValid, 1);
        if (outValid) begin
          if (expQ.size() == 0) chk("unexpected out word", outData, 64'hFFFF_FFFF_FFFF_FFFF);
          else chk("out data", outData, expQ[0]);
          if (outReady) begin
            if (expQ.size() != 0) void'(expQ.pop_front());
            gotQ.push_back(outData);
            gotT.push_back(cyc);
          end
        end
        prevStall = outValid && !outReady;
      end else begin
        prevStall = 1'b0;
      end
    end
  end

  task automatic hostWrite(input logic [HADDR_W-1:0] a, input logic [31:0] v);
    hostSel = 1'b1; hostWr = 1'b1; hostAddr = a; hostWData = v;
    @(negedge clk);
    hostSel = 1'b0; hostWr = 1'b0;
  endtask

  task automatic hostWriteRf(input int r, input logic [31:0] v);
    hostWrite(HADDR_W'(r), v);
    rfM[r] = v;
  endtask

  task automatic hostReadRf(input int r, output logic [31:0] v);
    hostSel = 1'b1; hostWr = 1'b0; hostAddr = HADDR_W'(r);
    @(negedge clk);
    v = hostRData;
    hostSel = 1'b0;
  endtask

  task automatic loadProg(input logic [17:0] p[$]);
    for (int i = 0; i < p.size(); i++) begin
      hostWrite({1'b1, 6'(i)}, 32'(p[i]));
      progM[i] = p[i];
    end
  endtask

  task automatic startRun(input int n);
    start = 1'b1; iters = ITER_W'(n);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitDone(input int limit);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (done) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    chk("done seen", 64'(seen), 1);
    chk("busy low at done", busy, 0);
    chk("model queue drained", 64'(expQ.size()), 0);
  endtask

  task automatic runAndCheck(input int n, input int limit);
    modelRun(n);
    startRun(n);
    chk("busy after start", busy, 1);
    waitDone(limit);
  endtask

  // Global watchdog
  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [17:0] p[$];
    logic [31:0] v;
    rstN = 1'b0; start = 1'b0; iters = '0;
    hostSel = 1'b0; hostWr = 1'b0; hostAddr = '0; hostWData = '0;
    for (int i = 0; i < 32; i++) rfM[i] = 32'd0;
    for (int i = 0; i < IMEM_DEPTH; i++) progM[i] = {HALT, 15'd0};
    repeat (3) @(negedge clk);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset valid", outValid, 0);
    chk("reset data", outData, 0);
    rstN = 1'b1;
    @(negedge clk);
    checkEn = 1'b1;

    // T1: r1=5; ADD r2=r1,r1; PUSH r3=r2; HALT
    hostWriteRf(1, 32'd5);
    p = {}; p.push_back(enc(ADD, 2, 1, 1)); p.push_back(enc(PUSH, 3, 2, 0)); p.push_back(enc(HALT, 0, 0, 0));
    loadProg(p);
    gotQ = {};
    runAndCheck(1, 200);
    chk("t1 word count", 64'(gotQ.size()), 1);
    if (gotQ.size() > 0) chk("t1 word", gotQ[0], 32'h0000_000A);
    @(negedge clk);
    chk("t1 done one pulse", done, 0);

    // T2: back-to-back MUL -> ADD dependency
    hostWriteRf(1, 32'h0002_0000);
    hostWriteRf(2, 32'h0001_8000);
    p = {}; p.push_back(enc(MUL, 3, 1, 2)); p.push_back(enc(ADD, 4, 3, 3)); p.push_back(enc(HALT, 0, 0, 0));
    loadProg(p);
    runAndCheck(1, 200);
    hostReadRf(4, v);
    chk("t2 r4", v, 32'h0006_0000);
    chk("t2 r4 model", v, rfM[4]);

    // T3: backpressure for 10 cycles, then three words in order
    hostWriteRf(1, 32'd1); hostWriteRf(2, 32'd2); hostWriteRf(3, 32'd3);
    p = {}; p.push_back(enc(PUSH, 5, 1, 0)); p.push_back(enc(PUSH, 6, 2, 0));
    p.push_back(enc(PUSH, 7, 3, 0)); p.push_back(enc(HALT, 0, 0, 0));
    loadProg(p);
    gotQ = {};
    readyMode = 2;
    modelRun(1);
    startRun(1);
    repeat (10) @(negedge clk);
    chk("t3 held valid", outValid, 1);
    chk("t3 held data", outData, 32'd1);
    chk("t3 still busy", busy, 1);
    readyMode = 0;
    waitDone(200);
    chk("t3 count", 64'(gotQ.size()), 3);
    for (int i = 0; i < 3 && i < gotQ.size(); i++) chk("t3 order", gotQ[i], 32'(i + 1));

    // T4: SQRT values and 16-cycle occupancy of X (PUSH-to-PUSH gap = 1 + 16)
    hostWriteRf(1, 32'd1000000);
    hostWriteRf(2, 32'hFFFF_FFFF);
    p = {}; p.push_back(enc(PUSH, 9, 1, 0)); p.push_back(enc(SQRT, 3, 1, 0));
    p.push_back(enc(PUSH, 10, 3, 0)); p.push_back(enc(SQRT, 4, 2, 0));
    p.push_back(enc(PUSH, 11, 4, 0)); p.push_back(enc(HALT, 0, 0, 0));
    loadProg(p);
    gotQ = {}; gotT = {};
    runAndCheck(1, 300);
    chk("t4 count", 64'(gotQ.size()), 3);
    if (gotQ.size() == 3) begin
      chk("t4 sqrt 1e6", gotQ[1], 32'd1000);
      chk("t4 sqrt max", gotQ[2], 32'h0000_FFFF);
      chk("t4 gap1", 64'(gotT[1] - gotT[0]), 17);
      chk("t4 gap2", 64'(gotT[2] - gotT[1]), 17);
    end

    // T5: r0 iteration index over 4 iterations; host write while busy ignored
    hostWriteRf(5, 32'h0000_1111);
    p = {}; p.push_back(enc(PUSH, 1, 0, 0)); p.push_back(enc(HALT, 0, 0, 0));
    loadProg(p);
    gotQ = {};
    modelRun(4);
    startRun(4);
    hostWrite(HADDR_W'(5), 32'h0000_DEAD);
    chk("t5 busy", busy, 1);
    waitDone(200);
    chk("t5 count", 64'(gotQ.size()), 4);
    for (int i = 0; i < 4 && i < gotQ.size(); i++) chk("t5 index", gotQ[i], 32'(i));
    hostReadRf(5, v);
    chk("t5 r5 untouched", v, 32'h0000_1111);

    // Randomized programs against the model
    for (int t = 0; t < 6; t++) begin
      int len, n;
      bit hasPush;
      for (int r = 1; r < 32; r++) hostWriteRf(r, $urandom);
      len = int'($urandom_range(3, 12));
      p = {};
      hasPush = 1'b0;
      for (int i = 0; i < len; i++) begin
        logic [2:0] op;
        op = 3'($urandom_range(0, 6));
        if (op == PUSH) hasPush = 1'b1;
        p.push_back(enc(op, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), int'($urandom_range(0, 31))));
      end
      if (!hasPush) p.push_back(enc(PUSH, int'($urandom_range(1, 31)), int'($urandom_range(0, 31)), 0));
      p.push_back(enc(HALT, 0, 0, 0));
      loadProg(p);
      n = int'($urandom_range(1, 3));
      readyMode = 1;
      runAndCheck(n, 5000);
      readyMode = 0;
      for (int r = 1; r < 32; r++) begin
        hostReadRf(r, v);
        chk($sformatf("rand%0d r%0d", t, r), v, rfM[r]);
      end
    end

    // T6: asynchronous reset mid-run, then a zero-iteration start
    p = {}; p.push_back(enc(PUSH, 1, 0, 0)); p.push_back(enc(HALT, 0, 0, 0));
    loadProg(p);
    checkEn = 1'b0;
    readyMode = 2;
    startRun(1000);
    repeat (5) @(negedge clk);
    chk("t6 valid before reset", outValid, 1);
    #2 rstN = 1'b0;
    #1;
    chk("t6 async valid", outValid, 0);
    chk("t6 async busy", busy, 0);
    @(negedge clk);
    rstN = 1'b1;
    readyMode = 0;
    expQ = {};
    @(negedge clk);
    checkEn = 1'b1;
    startRun(0);
    chk("t6 n0 done", done, 1);
    chk("t6 n0 busy", busy, 0);
    @(negedge clk);
    chk("t6 n0 done pulse", done, 0);
    repeat (5) @(negedge clk);
    chk("t6 n0 no output", outValid, 0);
    chk("t6 n0 idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
